// File: rtl/nesctrl_emu.sv
// nesctrl_emu: device-side emulator of an NES controller (4021-style PISO shift register).
//
// The host driver latches the pad with nes_pl and clocks bits out with nes_clk; both pins are
// asynchronous to clk_i and pass through synchronizers before any edge is judged. Button state
// arrives over a valid/ready handshake into a one-word pending buffer and is copied into the
// shadow register only between frames, so a frame never mixes two words.
//
// Ports:
//   clk_i            system clock
//   rst_ni           asynchronous reset, active-low
//   buttons_i        button word, 1 = pressed; bit7..0 = A,B,Select,Start,Up,Down,Left,Right
//   buttons_valid_i  buttons_i offered
//   buttons_ready_o  pending buffer empty; word accepted when valid and ready are both high
//   turbo_mask_i     (NESCTRL_EMU_TURBO_EN only) buttons that auto-release on odd frames
//   nes_pl_i         host latch pin
//   nes_clk_i        host shift clock pin
//   nes_q7_o         serial data, active-low (0 = pressed), registered
//   frame_cnt_o      completed 8-bit reads, wraps to 0
//   timeout_o        sticky, set when a read stalls in SHIFT for TIMEOUT_CYCLES clocks
//   timeout_clr_i    clears timeout_o (a same-cycle set wins)
//
// Optional feature macro: NESCTRL_EMU_TURBO_EN adds turbo_mask_i.

module nesctrl_emu #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned FRAME_CNT_W    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [7:0]             buttons_i,
  input  logic                   buttons_valid_i,
  output logic                   buttons_ready_o,
`ifdef NESCTRL_EMU_TURBO_EN
  input  logic [7:0]             turbo_mask_i,
`endif
  input  logic                   nes_pl_i,
  input  logic                   nes_clk_i,
  output logic                   nes_q7_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o,
  output logic                   timeout_o,
  input  logic                   timeout_clr_i
);

  localparam int unsigned WdogW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StDone
  } state_e;

  // --------------------------------------------------------------------------------------------
  // Pin synchronizers and edge detection
  // --------------------------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] pl_sync_q;
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic                   pl_d1_q;
  logic                   clk_d1_q;
  logic                   pl_s;
  logic                   clk_s;
  logic                   pl_fall;
  logic                   clk_rise;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pl_sync_q  <= '0;
      clk_sync_q <= '0;
      pl_d1_q    <= 1'b0;
      clk_d1_q   <= 1'b0;
    end else begin
      pl_sync_q  <= {pl_sync_q[SYNC_STAGES-2:0], nes_pl_i};
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], nes_clk_i};
      pl_d1_q    <= pl_s;
      clk_d1_q   <= clk_s;
    end
  end

  assign pl_s     = pl_sync_q[SYNC_STAGES-1];
  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign pl_fall  = ~pl_s & pl_d1_q;
  assign clk_rise = clk_s & ~clk_d1_q;

  // --------------------------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [7:0]             shift_reg_q, shift_reg_d;
  logic [7:0]             shadow_q, shadow_d;
  logic [7:0]             pending_q, pending_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [WdogW-1:0]       wdog_q, wdog_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   timeout_q, timeout_d;
  logic                   q7_q;

  // Control strobes from the output process
  logic load_en;
  logic shift_en;
  logic frame_done;
  logic abort;
  logic wdog_inc;
  logic xfer_ok;

  logic [7:0] load_val;

`ifdef NESCTRL_EMU_TURBO_EN
  // Masked buttons read pressed on even frames and released on odd frames.
  assign load_val = ~(shadow_q & ~(turbo_mask_i & {8{frame_cnt_q[0]}}));
`else
  assign load_val = ~shadow_q;
`endif

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic. A high latch forces LOAD from every state, so a relatch mid-read
  // restarts the frame and overrides both shift edges and the watchdog.
  always_comb begin
    state_d = state_q;
    if (pl_s) begin
      state_d = StLoad;
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        // LOAD is only entered with pl_s high, so pl_d1_q is high here and the fall is seen.
        StLoad: if (pl_fall) state_d = StShift;
        StShift: begin
          if (frame_done) begin
            state_d = StDone;
          end else if (abort) begin
            state_d = StIdle;
          end
        end
        StDone: state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM output logic: control strobes for the datapath
  always_comb begin
    load_en    = 1'b0;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    abort      = 1'b0;
    wdog_inc   = 1'b0;
    xfer_ok    = 1'b0;
    if (pl_s) begin
      load_en = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: xfer_ok = 1'b1;
        StLoad: ;
        StShift: begin
          if (clk_rise) begin
            shift_en   = 1'b1;
            frame_done = (bit_cnt_q == 4'd7);
          end else if (wdog_q == WdogLast) begin
            abort = 1'b1;
          end else begin
            wdog_inc = 1'b1;
          end
        end
        StDone: begin
          xfer_ok  = 1'b1;
          shift_en = clk_rise;
        end
        default: ;
      endcase
    end
  end

  // Datapath next-state
  always_comb begin
    shift_reg_d  = shift_reg_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    pend_valid_d = pend_valid_q;
    bit_cnt_d    = bit_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    timeout_d    = timeout_q;

    // Watchdog only runs while waiting for a shift edge; everything else clears it.
    wdog_d = wdog_inc ? (wdog_q + 1'b1) : '0;

    if (load_en) begin
      shift_reg_d = load_val;
      bit_cnt_d   = '0;
    end else if (abort) begin
      shift_reg_d = 8'hFF;
    end else if (shift_en) begin
      // Serial fill is 1 so reads past bit 8 report "released".
      shift_reg_d = {shift_reg_q[6:0], 1'b1};
      if (state_q == StShift) begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end

    if (frame_done) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end

    if (abort) begin
      timeout_d = 1'b1;
    end else if (timeout_clr_i) begin
      timeout_d = 1'b0;
    end

    // Accept and transfer are mutually exclusive: accept needs an empty buffer, transfer a full
    // one. The load above always uses shadow_q, so a coincident transfer takes effect next cycle.
    if (buttons_valid_i && !pend_valid_q) begin
      pending_d    = buttons_i;
      pend_valid_d = 1'b1;
    end else if (xfer_ok && pend_valid_q) begin
      shadow_d     = pending_q;
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_reg_q  <= 8'hFF;
      shadow_q     <= 8'h00;
      pending_q    <= 8'h00;
      pend_valid_q <= 1'b0;
      bit_cnt_q    <= '0;
      wdog_q       <= '0;
      frame_cnt_q  <= '0;
      timeout_q    <= 1'b0;
      q7_q         <= 1'b1;
    end else begin
      shift_reg_q  <= shift_reg_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
      bit_cnt_q    <= bit_cnt_d;
      wdog_q       <= wdog_d;
      frame_cnt_q  <= frame_cnt_d;
      timeout_q    <= timeout_d;
      q7_q         <= shift_reg_q[7];
    end
  end

  assign nes_q7_o        = q7_q;
  assign buttons_ready_o = ~pend_valid_q;
  assign frame_cnt_o     = frame_cnt_q;
  assign timeout_o       = timeout_q;

endmodule
